test_pattern_source: RTL and testbench

TEST_PATTERN_SOURCE -- requirements
Module: test_pattern_source

---
 rtl/hdmi_pkg.sv | 36 +++
 rtl/video_timing.sv | 58 +++++
 rtl/test_pattern_source.sv | 126 ++++++++++++
 tb/tb_test_pattern_source.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/hdmi_pkg.sv
// Shared video definitions: default 640x480 timing, pattern encodings and the colour-bar table.
package hdmi_pkg;

  localparam int H_ACTIVE_DEF = 640;
  localparam int H_FP_DEF     = 16;
  localparam int H_SYNC_DEF   = 96;
  localparam int H_BP_DEF     = 48;
  localparam int V_ACTIVE_DEF = 480;
  localparam int V_FP_DEF     = 10;
  localparam int V_SYNC_DEF   = 2;
  localparam int V_BP_DEF     = 33;

  typedef enum logic [1:0] {
    PAT_BARS   = 2'd0,
    PAT_GREY   = 2'd1,
    PAT_CHECK  = 2'd2,
    PAT_SCROLL = 2'd3
  } pattern_t;

  // Returns {r,g,b} on/off flags for bar 0..7 (white, yellow, cyan, green, magenta, red, blue, black)
  function automatic logic [2:0] bar_rgb(input logic [2:0] bar);
    logic [2:0] rgb;
    case (bar)
      3'd0:    rgb = 3'b111;
      3'd1:    rgb = 3'b110;
      3'd2:    rgb = 3'b011;
      3'd3:    rgb = 3'b010;
      3'd4:    rgb = 3'b101;
      3'd5:    rgb = 3'b100;
      3'd6:    rgb = 3'b001;
      default: rgb = 3'b000;
    endcase
    return rgb;
  endfunction

endpackage

// File: rtl/video_timing.sv
// Free-running raster counters with combinational de/sync decode of the current position.
module video_timing
  import hdmi_pkg::*;
#(
  parameter int   H_ACTIVE  = H_ACTIVE_DEF,
  parameter int   H_FP      = H_FP_DEF,
  parameter int   H_SYNC    = H_SYNC_DEF,
  parameter int   H_BP      = H_BP_DEF,
  parameter int   V_ACTIVE  = V_ACTIVE_DEF,
  parameter int   V_FP      = V_FP_DEF,
  parameter int   V_SYNC    = V_SYNC_DEF,
  parameter int   V_BP      = V_BP_DEF,
  parameter logic HSYNC_POL = 1'b0,
  parameter logic VSYNC_POL = 1'b0
) (
  input  logic        pixel_clk,
  input  logic        rst_n,
  output logic [11:0] h_cnt,
  output logic [11:0] v_cnt,
  output logic        de_c,
  output logic        hsync_c,
  output logic        vsync_c,
  output logic        frame_wrap
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  logic h_last;
  logic v_last;

  assign h_last     = (h_cnt == 12'(H_TOTAL - 1));
  assign v_last     = (v_cnt == 12'(V_TOTAL - 1));
  assign frame_wrap = h_last && v_last;

  always_ff @(posedge pixel_clk or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt <= 12'd0;
      v_cnt <= 12'd0;
    end else if (h_last) begin
      h_cnt <= 12'd0;
      v_cnt <= v_last ? 12'd0 : v_cnt + 12'd1;
    end else begin
      h_cnt <= h_cnt + 12'd1;
    end
  end

  logic h_in_sync;
  logic v_in_sync;

  assign h_in_sync = (h_cnt >= 12'(H_ACTIVE + H_FP)) && (h_cnt < 12'(H_ACTIVE + H_FP + H_SYNC));
  assign v_in_sync = (v_cnt >= 12'(V_ACTIVE + V_FP)) && (v_cnt < 12'(V_ACTIVE + V_FP + V_SYNC));

  assign de_c    = (h_cnt < 12'(H_ACTIVE)) && (v_cnt < 12'(V_ACTIVE));
  assign hsync_c = h_in_sync ? HSYNC_POL : ~HSYNC_POL;
  assign vsync_c = v_in_sync ? VSYNC_POL : ~VSYNC_POL;

endmodule

// File: rtl/test_pattern_source.sv
// Video test pattern generator: selects one of four patterns per frame and registers all outputs.
module test_pattern_source
  import hdmi_pkg::*;
#(
  parameter int   H_ACTIVE  = H_ACTIVE_DEF,
  parameter int   H_FP      = H_FP_DEF,
  parameter int   H_SYNC    = H_SYNC_DEF,
  parameter int   H_BP      = H_BP_DEF,
  parameter int   V_ACTIVE  = V_ACTIVE_DEF,
  parameter int   V_FP      = V_FP_DEF,
  parameter int   V_SYNC    = V_SYNC_DEF,
  parameter int   V_BP      = V_BP_DEF,
  parameter logic HSYNC_POL = 1'b0,
  parameter logic VSYNC_POL = 1'b0
) (
  input  logic        pixel_clk,
  input  logic        rst_n,
  input  logic [1:0]  pattern_sel,
  output logic        de,
  output logic        hsync,
  output logic        vsync,
  output logic [7:0]  pixel_data [0:2],
  output logic [11:0] x,
  output logic [11:0] y,
  output logic        frame_start,
  output logic [7:0]  frame_cnt
);

  localparam int BAR_W = (H_ACTIVE >= 8) ? H_ACTIVE / 8 : 1;

  logic [11:0] h_cnt;
  logic [11:0] v_cnt;
  logic        de_c;
  logic        hsync_c;
  logic        vsync_c;
  logic        frame_wrap;
  pattern_t    active_pat;

  video_timing #(
    .H_ACTIVE (H_ACTIVE), .H_FP (H_FP), .H_SYNC (H_SYNC), .H_BP (H_BP),
    .V_ACTIVE (V_ACTIVE), .V_FP (V_FP), .V_SYNC (V_SYNC), .V_BP (V_BP),
    .HSYNC_POL(HSYNC_POL), .VSYNC_POL(VSYNC_POL)
  ) u_timing (
    .pixel_clk (pixel_clk),
    .rst_n     (rst_n),
    .h_cnt     (h_cnt),
    .v_cnt     (v_cnt),
    .de_c      (de_c),
    .hsync_c   (hsync_c),
    .vsync_c   (vsync_c),
    .frame_wrap(frame_wrap)
  );

  logic [11:0] bar_q;
  logic [2:0]  bar;
  logic [2:0]  bar_on;
  logic [7:0]  red_c;
  logic [7:0]  green_c;
  logic [7:0]  blue_c;

  assign bar_q  = h_cnt / 12'(BAR_W);
  assign bar    = (bar_q > 12'd7) ? 3'd7 : bar_q[2:0];
  assign bar_on = bar_rgb(bar);

  always_comb begin
    red_c   = 8'h00;
    green_c = 8'h00;
    blue_c  = 8'h00;
    if (de_c) begin
      case (active_pat)
        PAT_BARS: begin
          red_c   = {8{bar_on[2]}};
          green_c = {8{bar_on[1]}};
          blue_c  = {8{bar_on[0]}};
        end
        PAT_GREY: begin
          red_c   = h_cnt[7:0];
          green_c = h_cnt[7:0];
          blue_c  = h_cnt[7:0];
        end
        PAT_CHECK: begin
          red_c   = {8{h_cnt[3] ^ v_cnt[3]}};
          green_c = {8{h_cnt[3] ^ v_cnt[3]}};
          blue_c  = {8{h_cnt[3] ^ v_cnt[3]}};
        end
        default: begin
          // frame_cnt has already advanced at the wrap, so the scroll offset is the new frame's count
          red_c   = h_cnt[7:0] + frame_cnt;
          green_c = v_cnt[7:0];
          blue_c  = 8'h80;
        end
      endcase
    end
  end

  always_ff @(posedge pixel_clk or negedge rst_n) begin
    if (!rst_n) begin
      de            <= 1'b0;
      hsync         <= ~HSYNC_POL;
      vsync         <= ~VSYNC_POL;
      x             <= 12'd0;
      y             <= 12'd0;
      frame_start   <= 1'b0;
      frame_cnt     <= 8'd0;
      active_pat    <= PAT_BARS;
      pixel_data[0] <= 8'h00;
      pixel_data[1] <= 8'h00;
      pixel_data[2] <= 8'h00;
    end else begin
      de            <= de_c;
      hsync         <= hsync_c;
      vsync         <= vsync_c;
      x             <= de_c ? h_cnt : 12'd0;
      y             <= de_c ? v_cnt : 12'd0;
      frame_start   <= de_c && (h_cnt == 12'd0) && (v_cnt == 12'd0);
      pixel_data[0] <= blue_c;
      pixel_data[1] <= green_c;
      pixel_data[2] <= red_c;
      if (frame_wrap) begin
        frame_cnt  <= frame_cnt + 8'd1;
        active_pat <= pattern_t'(pattern_sel);
      end
    end
  end

endmodule

// File: tb/tb_test_pattern_source.sv
// Directed bench for test_pattern_source on a reduced 24x10 raster so that 256 frames stay short.
module tb_test_pattern_source;

  localparam int HT    = 24;
  localparam int VT    = 10;
  localparam int FRAME = HT * VT;

  logic        pixel_clk = 1'b0;
  logic        rst_n;
  logic [1:0]  pattern_sel;
  logic        de;
  logic        hsync;
  logic        vsync;
  logic [7:0]  pixel_data [0:2];
  logic [11:0] x;
  logic [11:0] y;
  logic        frame_start;
  logic [7:0]  frame_cnt;

  int checks = 0;
  int errors = 0;
  int k      = 0;

  always #5 pixel_clk = ~pixel_clk;

  test_pattern_source #(
    .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(6),  .V_FP(1), .V_SYNC(2), .V_BP(1),
    .HSYNC_POL(1'b0), .VSYNC_POL(1'b1)
  ) dut (
    .pixel_clk  (pixel_clk),
    .rst_n      (rst_n),
    .pattern_sel(pattern_sel),
    .de         (de),
    .hsync      (hsync),
    .vsync      (vsync),
    .pixel_data (pixel_data),
    .x          (x),
    .y          (y),
    .frame_start(frame_start),
    .frame_cnt  (frame_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h (k=%0d)", tag, obs, exp, k);
    end
  endtask

  task automatic step();
    @(negedge pixel_clk);
    k++;
  endtask

  function automatic logic [31:0] rgb();
    return {8'h00, pixel_data[2], pixel_data[1], pixel_data[0]};
  endfunction

  task automatic chk_reset_state(input string tag);
    chk({tag, "_de"}, 32'(de), 32'd0);
    chk({tag, "_hsync"}, 32'(hsync), 32'd1);
    chk({tag, "_vsync"}, 32'(vsync), 32'd0);
    chk({tag, "_xy"}, {8'h0, x, y}, 32'd0);
    chk({tag, "_fs"}, 32'(frame_start), 32'd0);
    chk({tag, "_fcnt"}, 32'(frame_cnt), 32'd0);
    chk({tag, "_pix"}, rgb(), 32'd0);
  endtask

  initial begin
    int de_cnt = 0, fs_cnt = 0, hs_cnt = 0, vs_cnt = 0, blank_bad = 0;
    int hs_first = -1, vs_first = -1;
    logic [31:0] px_k1 = '0, px_k2 = '0, px_k15 = '0, px_k16 = '0, px_k98 = '0, xy_k76 = '0;

    rst_n       = 1'b0;
    pattern_sel = 2'd0;
    repeat (3) @(negedge pixel_clk);
    chk_reset_state("rst");

    rst_n = 1'b1;
    step();
    k = 0;
    chk("first_de", 32'(de), 32'd1);
    chk("first_xy", {8'h0, x, y}, 32'd0);
    chk("first_fs", 32'(frame_start), 32'd1);
    chk("first_pix_white", rgb(), 32'hFFFFFF);

    // Frame 0: free-run scan, with a mid-frame pattern request at line 3
    for (int i = 1; i < FRAME; i++) begin
      step();
      if (k == 72) pattern_sel = 2'd2;
      if (de) de_cnt++;
      if (frame_start) fs_cnt++;
      if (hsync == 1'b0) begin
        hs_cnt++;
        if (hs_first < 0) hs_first = k;
      end
      if (vsync == 1'b1) begin
        vs_cnt++;
        if (vs_first < 0) vs_first = k;
      end
      if (!de && (x != 0 || y != 0 || rgb() != 0)) blank_bad++;
      if (k == 1)  px_k1  = rgb();
      if (k == 2)  px_k2  = rgb();
      if (k == 15) px_k15 = rgb();
      if (k == 16) px_k16 = rgb();
      if (k == 98) px_k98 = rgb();
      if (k == 76) xy_k76 = {8'h0, x, y};
    end
    chk("f0_de_cycles", de_cnt, 32'd95);
    chk("f0_fs_extra", fs_cnt, 32'd0);
    chk("f0_hsync_first", hs_first, 32'd18);
    chk("f0_hsync_low_cycles", hs_cnt, 32'd30);
    chk("f0_vsync_first", vs_first, 32'd168);
    chk("f0_vsync_cycles", vs_cnt, 32'd48);
    chk("f0_blank_zero", blank_bad, 32'd0);
    chk("bars_x1_white", px_k1, 32'hFFFFFF);
    chk("bars_x2_yellow", px_k2, 32'hFFFF00);
    chk("bars_x15_black", px_k15, 32'h000000);
    chk("blank_x16", px_k16, 32'h000000);
    chk("bars_after_sel_change", px_k98, 32'hFFFF00);
    chk("xy_k76", xy_k76, {8'h0, 12'd4, 12'd3});

    // Frame 1: checkerboard loaded at the wrap
    step();
    chk("f1_fs", 32'(frame_start), 32'd1);
    chk("f1_fcnt", 32'(frame_cnt), 32'd1);
    chk("check_x0_black", rgb(), 32'h000000);
    repeat (8) step();
    chk("check_x8_x", 32'(x), 32'd8);
    chk("check_x8_white", rgb(), 32'hFFFFFF);

    pattern_sel = 2'd1;
    while (k < 2 * FRAME + 13) step();
    chk("grey_x13", rgb(), 32'h0D0D0D);

    pattern_sel = 2'd3;
    while (k < 3 * FRAME) step();
    chk("f3_fcnt", 32'(frame_cnt), 32'd3);
    chk("scroll_x0y0", rgb(), 32'h030080);
    while (k < 3 * FRAME + 2 * HT + 5) step();
    chk("scroll_x5y2", rgb(), 32'h080280);

    fs_cnt = 0;
    while (k < 256 * FRAME - 2) begin
      step();
      if (frame_start) fs_cnt++;
    end
    chk("fs_once_per_frame", fs_cnt, 32'd252);
    chk("fcnt_255", 32'(frame_cnt), 32'd255);
    step();
    chk("fcnt_wrap_0", 32'(frame_cnt), 32'd0);
    step();
    chk("f256_fs", 32'(frame_start), 32'd1);
    chk("scroll_f256_x0y0", rgb(), 32'h000080);

    // Mid-frame reset at x=9, y=3
    while (k < 256 * FRAME + 3 * HT + 9) step();
    chk("pre_reset_xy", {8'h0, x, y}, {8'h0, 12'd9, 12'd3});
    rst_n = 1'b0;
    #1;
    chk_reset_state("async_rst");
    repeat (3) @(negedge pixel_clk);
    chk_reset_state("held_rst");
    rst_n = 1'b1;
    step();
    k = 0;
    chk("rel_de", 32'(de), 32'd1);
    chk("rel_xy", {8'h0, x, y}, 32'd0);
    chk("rel_fs", 32'(frame_start), 32'd1);
    chk("rel_pix_bars", rgb(), 32'hFFFFFF);
    step();
    chk("rel_x1", {8'h0, x, y}, {8'h0, 12'd1, 12'd0});
    while (k < HT) step();
    chk("rel_line1_xy", {8'h0, x, y}, {8'h0, 12'd0, 12'd1});
    chk("rel_line1_fs", 32'(frame_start), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
